// File: rtl/nco_cnt_disp_gen.sv
// Phase-accumulator NCO driving an N_DIG-digit BCD up/down counter with a multiplexed 7-segment scanner.
// Latency: o_tick one cycle after accumulator carry; o_cnt/o_wrap one cycle after the tick; segment outputs one cycle after index/count.
// Backpressure: none; free-running datapath, counter gated only by i_cnt_en and overridden by i_clr.
module nco_cnt_disp_gen #(
  parameter int N_DIG    = 6,
  parameter int NCO_W    = 32,
  parameter int SCAN_DIV = 50000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NCO_W-1:0]   i_nco_num,
  input  logic               i_cnt_en,
  input  logic               i_up,
  input  logic               i_clr,
  input  logic               i_blank_lz,
  output logic               o_tick,
  output logic               o_wrap,
  output logic [4*N_DIG-1:0] o_cnt,
  output logic [6:0]         o_seg,
  output logic               o_seg_dp,
  output logic [N_DIG-1:0]   o_seg_enb
);

  localparam int IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam int DIV_W = $clog2(SCAN_DIV);

  logic [NCO_W-1:0]   acc_q;
  logic [NCO_W:0]     acc_sum;
  logic               tick_q;
  logic [4*N_DIG-1:0] cnt_q, cnt_d;
  logic               roll_d;
  logic               wrap_q;
  logic [DIV_W-1:0]   div_q;
  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   hi_nz;
  logic [3:0]         cur_dig;
  logic [6:0]         seg_q, seg_d;
  logic               dp_q, dp_d;
  logic [N_DIG-1:0]   enb_q, enb_d;

  // Segment pattern for one BCD digit, bit0 = segment a.
  function automatic logic [6:0] seg_decode(input logic [3:0] dig);
    case (dig)
      4'd0:    seg_decode = 7'h3F;
      4'd1:    seg_decode = 7'h06;
      4'd2:    seg_decode = 7'h5B;
      4'd3:    seg_decode = 7'h4F;
      4'd4:    seg_decode = 7'h66;
      4'd5:    seg_decode = 7'h6D;
      4'd6:    seg_decode = 7'h7D;
      4'd7:    seg_decode = 7'h07;
      4'd8:    seg_decode = 7'h7F;
      4'd9:    seg_decode = 7'h6F;
      default: seg_decode = 7'h00;
    endcase
  endfunction

  // Extra top bit of the sum is the carry out of the accumulator.
  assign acc_sum = {1'b0, acc_q} + {1'b0, i_nco_num};

  // Phase accumulator; the carry is registered as the tick pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      acc_q  <= acc_sum[NCO_W-1:0];
      tick_q <= acc_sum[NCO_W];
    end
  end

  // Ripple BCD increment/decrement; carry surviving past the top digit means the count rolled over.
  always_comb begin
    logic carry;
    cnt_d = cnt_q;
    carry = 1'b1;
    for (int i = 0; i < N_DIG; i++) begin
      if (carry) begin
        if (i_up) begin
          if (cnt_q[4*i +: 4] == 4'd9) begin
            cnt_d[4*i +: 4] = 4'd0;
          end else begin
            cnt_d[4*i +: 4] = cnt_q[4*i +: 4] + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (cnt_q[4*i +: 4] == 4'd0) begin
            cnt_d[4*i +: 4] = 4'd9;
          end else begin
            cnt_d[4*i +: 4] = cnt_q[4*i +: 4] - 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
    roll_d = carry;
  end

  // Counter state: clear wins over a tick, and the wrap flag only pulses on an actual rollover update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else if (i_clr) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else if (tick_q && i_cnt_en) begin
      cnt_q  <= cnt_d;
      wrap_q <= roll_d;
    end else begin
      wrap_q <= 1'b0;
    end
  end

  // Scan timing: divider sets the slot length, index steps through the digits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      idx_q <= '0;
    end else if (div_q == DIV_W'(SCAN_DIV - 1)) begin
      div_q <= '0;
      idx_q <= (idx_q == IDX_W'(N_DIG - 1)) ? '0 : idx_q + IDX_W'(1);
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  // Select the scanned digit, find the most significant nonzero digit, and build next display outputs.
  always_comb begin
    hi_nz   = '0;
    cur_dig = 4'd0;
    enb_d   = '1;
    for (int i = 0; i < N_DIG; i++) begin
      if (cnt_q[4*i +: 4] != 4'd0) hi_nz = IDX_W'(i);
      if (idx_q == IDX_W'(i)) begin
        cur_dig  = cnt_q[4*i +: 4];
        enb_d[i] = 1'b0;
      end
    end
    // Digit 0 is never blanked since hi_nz is at least 0.
    seg_d = (i_blank_lz && (idx_q > hi_nz)) ? 7'h00 : seg_decode(cur_dig);
    dp_d  = (idx_q == '0) && !i_up;
  end

  // Registered display outputs, one cycle behind the scan index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= '0;
      dp_q  <= 1'b0;
      enb_q <= '1;
    end else begin
      seg_q <= seg_d;
      dp_q  <= dp_d;
      enb_q <= enb_d;
    end
  end

  assign o_tick    = tick_q;
  assign o_wrap    = wrap_q;
  assign o_cnt     = cnt_q;
  assign o_seg     = seg_q;
  assign o_seg_dp  = dp_q;
  assign o_seg_enb = enb_q;

endmodule

// File: tb/tb_nco_cnt_disp_gen.sv
// Directed bench for nco_cnt_disp_gen: NCO tick spacing, BCD up/down/wrap/clear/hold,
// digit scan with and without leading-zero blanking, decimal point, and mid-scan reset.
module tb_nco_cnt_disp_gen;

  localparam int N_DIG    = 6;
  localparam int NCO_W    = 32;
  localparam int SCAN_DIV = 4;

  logic               clk;
  logic               rst_n;
  logic [NCO_W-1:0]   i_nco_num;
  logic               i_cnt_en;
  logic               i_up;
  logic               i_clr;
  logic               i_blank_lz;
  logic               o_tick;
  logic               o_wrap;
  logic [4*N_DIG-1:0] o_cnt;
  logic [6:0]         o_seg;
  logic               o_seg_dp;
  logic [N_DIG-1:0]   o_seg_enb;

  int n_chk  = 0;
  int n_fail = 0;

  nco_cnt_disp_gen #(
    .N_DIG   (N_DIG),
    .NCO_W   (NCO_W),
    .SCAN_DIV(SCAN_DIV)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_nco_num (i_nco_num),
    .i_cnt_en  (i_cnt_en),
    .i_up      (i_up),
    .i_clr     (i_clr),
    .i_blank_lz(i_blank_lz),
    .o_tick    (o_tick),
    .o_wrap    (o_wrap),
    .o_cnt     (o_cnt),
    .o_seg     (o_seg),
    .o_seg_dp  (o_seg_dp),
    .o_seg_enb (o_seg_enb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Enable counting for exactly n ticks; called and returns on a falling edge.
  task automatic do_ticks(input int n);
    int seen;
    int cyc;
    seen = 0;
    cyc  = 0;
    i_cnt_en = 1'b1;
    while (seen < n && cyc < 4 * n + 20) begin
      if (o_tick) seen++;
      @(negedge clk);
      cyc++;
    end
    i_cnt_en = 1'b0;
    if (seen < n) chk("tick_timeout", seen, n);
  endtask

  // Align to the first cycle of digit-0 slot (previous slot was the top digit).
  task automatic sync_slot0(input string tag);
    logic [N_DIG-1:0] prev;
    logic             found;
    prev  = o_seg_enb;
    found = 1'b0;
    for (int k = 0; k < 80 && !found; k++) begin
      @(negedge clk);
      if (o_seg_enb == 6'b111110 && prev == 6'b011111) found = 1'b1;
      prev = o_seg_enb;
    end
    if (!found) chk(tag, o_seg_enb, 6'b111110);
  endtask

  // Walk one full scan frame checking enables and segments every cycle.
  task automatic scan_pass(input logic blank, input logic [6:0] seg_tab [N_DIG]);
    logic [N_DIG-1:0] exp_enb;
    i_blank_lz = blank;
    sync_slot0("scan_sync");
    for (int d = 0; d < N_DIG; d++) begin
      exp_enb = '1;
      exp_enb[d] = 1'b0;
      for (int c = 0; c < SCAN_DIV; c++) begin
        chk($sformatf("enb_b%0d_d%0d_c%0d", blank, d, c), o_seg_enb, exp_enb);
        chk($sformatf("seg_b%0d_d%0d_c%0d", blank, d, c), o_seg, seg_tab[d]);
        @(negedge clk);
      end
    end
  endtask

  initial begin
    int nt;
    logic [6:0] tab_blank [N_DIG];
    logic [6:0] tab_full  [N_DIG];
    logic       found;

    tab_blank = '{7'h5B, 7'h66, 7'h00, 7'h00, 7'h00, 7'h00};
    tab_full  = '{7'h5B, 7'h66, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

    rst_n      = 1'b0;
    i_nco_num  = 32'h4000_0000;
    i_cnt_en   = 1'b0;
    i_up       = 1'b1;
    i_clr      = 1'b0;
    i_blank_lz = 1'b1;
    repeat (3) @(negedge clk);

    chk("rst_tick", o_tick, 0);
    chk("rst_wrap", o_wrap, 0);
    chk("rst_cnt",  o_cnt, 0);
    chk("rst_seg",  o_seg, 0);
    chk("rst_dp",   o_seg_dp, 0);
    chk("rst_enb",  o_seg_enb, 6'h3F);

    // Quarter-scale increment: tick on every 4th cycle, first at cycle 4.
    rst_n = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      chk($sformatf("tick_q_c%0d", c), o_tick, (c % 4 == 0) ? 1 : 0);
    end

    i_nco_num = '0;
    nt = 0;
    repeat (1000) begin
      @(negedge clk);
      if (o_tick) nt++;
    end
    chk("tick_zero_inc", nt, 0);

    // Half-scale increment from here on.
    i_nco_num = 32'h8000_0000;
    @(negedge clk);

    i_up = 1'b0;
    do_ticks(1);
    chk("dn_from0_cnt",  o_cnt, 24'h999999);
    chk("dn_from0_wrap", o_wrap, 1);
    @(negedge clk);
    chk("dn_wrap_1cyc", o_wrap, 0);
    do_ticks(1);
    chk("dn_2_cnt",  o_cnt, 24'h999998);
    chk("dn_2_wrap", o_wrap, 0);

    i_up = 1'b1;
    do_ticks(1);
    chk("up_999999_cnt",  o_cnt, 24'h999999);
    chk("up_999999_wrap", o_wrap, 0);
    do_ticks(1);
    chk("up_wrap_cnt",  o_cnt, 24'h000000);
    chk("up_wrap_wrap", o_wrap, 1);
    @(negedge clk);
    chk("up_wrap_1cyc", o_wrap, 0);

    do_ticks(123);
    chk("up_123_cnt", o_cnt, 24'h000123);

    // Ticks keep pulsing while the counter holds.
    nt = 0;
    repeat (20) begin
      @(negedge clk);
      if (o_tick) nt++;
    end
    chk("hold_ticks", nt, 10);
    chk("hold_cnt", o_cnt, 24'h000123);

    // Clear on the same edge as an enabled tick.
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      if (o_tick) found = 1'b1;
      else @(negedge clk);
    end
    if (!found) chk("clr_tick_wait", o_tick, 1);
    i_clr    = 1'b1;
    i_cnt_en = 1'b1;
    @(negedge clk);
    i_clr    = 1'b0;
    i_cnt_en = 1'b0;
    chk("clr_cnt",  o_cnt, 0);
    chk("clr_wrap", o_wrap, 0);

    do_ticks(42);
    chk("up_42_cnt", o_cnt, 24'h000042);
    i_nco_num = '0;

    scan_pass(1'b1, tab_blank);
    scan_pass(1'b0, tab_full);

    // Decimal point marks down-count on digit 0 only.
    i_up = 1'b0;
    sync_slot0("dp_sync");
    chk("dp_dig0_down", o_seg_dp, 1);
    repeat (SCAN_DIV) @(negedge clk);
    chk("dp_dig1_down", o_seg_dp, 0);
    i_up = 1'b1;
    sync_slot0("dp_sync_up");
    chk("dp_dig0_up", o_seg_dp, 0);

    // Reach 000500, then reset while digit 3 is displayed.
    i_clr = 1'b1;
    @(negedge clk);
    i_clr = 1'b0;
    i_nco_num = 32'h8000_0000;
    do_ticks(500);
    chk("up_500_cnt", o_cnt, 24'h000500);
    i_nco_num = '0;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (o_seg_enb == 6'b110111) found = 1'b1;
    end
    if (!found) chk("idx3_wait", o_seg_enb, 6'b110111);

    rst_n = 1'b0;
    #1;
    chk("mid_rst_cnt",  o_cnt, 0);
    chk("mid_rst_seg",  o_seg, 0);
    chk("mid_rst_dp",   o_seg_dp, 0);
    chk("mid_rst_enb",  o_seg_enb, 6'h3F);
    chk("mid_rst_tick", o_tick, 0);
    chk("mid_rst_wrap", o_wrap, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= SCAN_DIV + 1; k++) begin
      @(negedge clk);
      chk($sformatf("post_rst_enb_%0d", k), o_seg_enb,
          (k <= SCAN_DIV) ? 6'b111110 : 6'b111101);
    end
    chk("post_rst_cnt", o_cnt, 0);
    chk("post_rst_seg0", o_seg, 7'h3F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
